// File: rtl/karatsuba_stream_io.sv
// Stream adapter around a wide multiplier: collects operand A and operand B
// as W-bit words (least-significant first), presents them to the multiplier,
// captures the 2N-bit product after MUL_LAT+1 cycles and streams it back out
// as W-bit words with a last-word flag. Loading and draining never overlap.
module karatsuba_stream_io #(
  parameter int N       = 256,
  parameter int W       = 32,
  parameter int MUL_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  input  logic [2*N-1:0]   prod,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int NW  = N / W;
  localparam int NWO = 2 * NW;
  localparam int KW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int JW  = $clog2(NWO);
  localparam int CW  = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NWO - 1);
  localparam logic [CW-1:0] C_LAST = CW'(MUL_LAT);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, DRAIN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [JW-1:0]    j;
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   prod_reg;

  // Output word is a pure decode of the product register and drain index.
  assign out_data = prod_reg[int'(j)*W +: W];

  // Sequencer: operand capture, multiplier wait, product drain, with all
  // handshake flags held in registers so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      k         <= '0;
      j         <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      prod_reg  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid && in_ready) begin
            op_a[int'(k)*W +: W] <= in_data;
            busy <= 1'b1;
            if (k == K_LAST) begin
              k     <= '0;
              state <= LOAD_B;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid && in_ready) begin
            op_b[int'(k)*W +: W] <= in_data;
            if (k == K_LAST) begin
              k        <= '0;
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= WAIT;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == C_LAST) begin
            prod_reg  <= prod;
            cnt       <= '0;
            j         <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (j == J_LAST) begin
              j         <= '0;
              k         <= '0;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= LOAD_A;
            end else begin
              j        <= j + JW'(1);
              out_last <= ((j + JW'(1)) == J_LAST);
            end
          end
        end
        default: begin
          state     <= LOAD_A;
          k         <= '0;
          j         <= '0;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
